// File: rtl/proc.sv
// Systolic-ring processing element: acc += (a * xr) >>> FRAC each cycle, xr <= x.
// Optional PROC_SAT_EN clamps the accumulator to the signed WIDTH range and adds a sat flag.
module proc #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] x_init,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
`ifdef PROC_SAT_EN
  ,
  output logic             sat
`endif
);

  logic signed [WIDTH-1:0]   xr;
  logic signed [WIDTH-1:0]   acc;
  logic signed [WIDTH-1:0]   acc_next;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] prod_sh;

  always_comb begin
    prod    = $signed(a) * xr;
    prod_sh = prod >>> FRAC;
  end

`ifdef PROC_SAT_EN
  logic signed [2*WIDTH:0] sum_f;
  logic signed [2*WIDTH:0] max_v;
  logic signed [2*WIDTH:0] min_v;
  logic                    sat_next;

  always_comb begin
    max_v    = $signed({{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}});
    min_v    = ~max_v;
    sum_f    = $signed({{(WIDTH+1){acc[WIDTH-1]}}, acc})
             + $signed({prod_sh[2*WIDTH-1], prod_sh});
    sat_next = 1'b0;
    acc_next = sum_f[WIDTH-1:0];
    if (sum_f > max_v) begin
      acc_next = $signed({1'b0, {(WIDTH-1){1'b1}}});
      sat_next = 1'b1;
    end else if (sum_f < min_v) begin
      acc_next = $signed({1'b1, {(WIDTH-1){1'b0}}});
      sat_next = 1'b1;
    end
  end
`else
  // Only the low WIDTH bits of the shifted product reach a wrapping accumulator.
  logic unused_prod_hi;
  assign unused_prod_hi = ^prod_sh[2*WIDTH-1:WIDTH];

  always_comb begin
    acc_next = acc + prod_sh[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      xr  <= x_init;
      acc <= '0;
`ifdef PROC_SAT_EN
      sat <= 1'b0;
`endif
    end else begin
      xr  <= x;
      acc <= acc_next;
`ifdef PROC_SAT_EN
      sat <= sat_next;
`endif
    end
  end

  assign y = acc;

endmodule

// File: tb/tb_proc.sv
// Bench for proc: two instances (FRAC=0 and FRAC=8) driven identically and
// compared against an integer-arithmetic reference model plus directed constants.
module tb_proc;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] x, x_init, a;
  logic [W-1:0] y0, y8;
  logic         sat0, sat8;

  int checks = 0;
  int errors = 0;

  longint m_xr, m_acc0, m_acc8;
  bit     m_sat0, m_sat8;

  always #5 clk = ~clk;

  proc #(.WIDTH(W), .FRAC(0)) dut (
    .clk(clk), .reset(reset), .x(x), .x_init(x_init), .a(a), .y(y0)
`ifdef PROC_SAT_EN
    , .sat(sat0)
`endif
  );

  proc #(.WIDTH(W), .FRAC(8)) dut_f (
    .clk(clk), .reset(reset), .x(x), .x_init(x_init), .a(a), .y(y8)
`ifdef PROC_SAT_EN
    , .sat(sat8)
`endif
  );

`ifndef PROC_SAT_EN
  assign sat0 = 1'b0;
  assign sat8 = 1'b0;
`endif

  function automatic longint to_s16(input longint v);
    longint r;
    r = v & 64'hFFFF;
    if (r >= 32768) r = r - 65536;
    return r;
  endfunction

  function automatic longint acc_step(input longint acc, input longint p,
                                      input int frac, output bit clamp);
    longint s;
    s = acc + (p >>> frac);
    clamp = 1'b0;
`ifdef PROC_SAT_EN
    if (s > 32767) begin
      s = 32767;
      clamp = 1'b1;
    end else if (s < -32768) begin
      s = -32768;
      clamp = 1'b1;
    end
`else
    s = to_s16(s);
`endif
    return s;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge: update the model from the inputs present at the edge, then compare.
  task automatic tick(input string tag);
    longint p;
    bit c0, c8;
    if (reset) begin
      m_xr   = longint'($signed(x_init));
      m_acc0 = 0;
      m_acc8 = 0;
      m_sat0 = 1'b0;
      m_sat8 = 1'b0;
    end else begin
      p      = longint'($signed(a)) * m_xr;
      m_acc0 = acc_step(m_acc0, p, 0, c0);
      m_acc8 = acc_step(m_acc8, p, 8, c8);
      m_sat0 = c0;
      m_sat8 = c8;
      m_xr   = longint'($signed(x));
    end
    @(posedge clk);
    #1;
    chk({tag, ".y0"}, y0, m_acc0[W-1:0]);
    chk({tag, ".y8"}, y8, m_acc8[W-1:0]);
`ifdef PROC_SAT_EN
    chk({tag, ".sat0"}, {15'b0, sat0}, {15'b0, m_sat0});
    chk({tag, ".sat8"}, {15'b0, sat8}, {15'b0, m_sat8});
`endif
  endtask

  initial begin
    reset = 1'b1; x = '0; x_init = '0; a = '0;
    m_xr = 0; m_acc0 = 0; m_acc8 = 0; m_sat0 = 1'b0; m_sat8 = 1'b0;

    // basic accumulation
    a = 16'd1; x = 16'd1; x_init = 16'd1;
    tick("rst");
    chk("rst_const", y0, 16'd0);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick("basic");
      chk("basic_const", y0, W'(i));
    end

    // preload vs circulate
    reset = 1'b1; x_init = 16'd3; x = 16'd5; a = 16'd2;
    tick("pre_rst");
    reset = 1'b0;
    tick("pre1"); chk("pre1_const", y0, 16'd6);
    tick("pre2"); chk("pre2_const", y0, 16'd16);
    tick("pre3"); chk("pre3_const", y0, 16'd26);

    // signed product
    reset = 1'b1; x_init = 16'hFFFE; x = 16'hFFFE; a = 16'd3;
    tick("sgn_rst");
    reset = 1'b0;
    tick("sgn1"); chk("sgn1_const", y0, 16'hFFFA);
    tick("sgn2"); chk("sgn2_const", y0, 16'hFFF4);

    // overflow
    reset = 1'b1; x_init = 16'h4000; x = 16'h4000; a = 16'd2;
    tick("ovf_rst");
    reset = 1'b0;
`ifdef PROC_SAT_EN
    tick("ovf1"); chk("ovf1_const", y0, 16'h7FFF); chk("ovf1_sat", {15'b0, sat0}, 16'd1);
    tick("ovf2"); chk("ovf2_const", y0, 16'h7FFF); chk("ovf2_sat", {15'b0, sat0}, 16'd1);
`else
    tick("ovf1"); chk("ovf1_const", y0, 16'h8000);
    tick("ovf2"); chk("ovf2_const", y0, 16'h0000);
`endif

    // reset mid-run, with undefined a/x on the reset edge
    reset = 1'b1; a = 16'd1; x = 16'd1; x_init = 16'd1;
    tick("mid_rst0");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick("mid_run");
    chk("mid_pre_const", y0, 16'd3);
    reset = 1'b1; x_init = 16'd7; a = 'x; x = 'x;
    @(posedge clk); #1;
    m_xr = 7; m_acc0 = 0; m_acc8 = 0; m_sat0 = 1'b0; m_sat8 = 1'b0;
    chk("mid_rst_y0", y0, 16'd0);
    chk("mid_rst_y8", y8, 16'd0);
    reset = 1'b0; a = 16'd1; x = 16'd1;
    tick("mid_post"); chk("mid_post_const", y0, 16'd7);

    // reset held several cycles: only the last x_init matters
    reset = 1'b1; a = 16'd3;
    for (int i = 0; i < 3; i++) begin
      x_init = W'(10 + i);
      tick("hold");
    end
    reset = 1'b0;
    tick("hold_rel"); chk("hold_rel_const", y0, 16'd36);

    // fixed point on the FRAC=8 instance
    reset = 1'b1; a = 16'h0180; x_init = 16'h0200; x = 16'h0200;
    tick("fx_rst");
    reset = 1'b0;
    tick("fx1"); chk("fx1_const", y8, 16'h0300);

    // randomized run against the model
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 19) == 0);
      a      = W'($urandom);
      x      = W'($urandom);
      x_init = W'($urandom);
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 7));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
